// File: rtl/chacha_pkg.sv
// Shared constants, FSM state type and the tail-word byte-mask helper for the ChaCha keystream XOR stage.
// The mask helper is only referenced when CHACHA_XOR_BYTEMASK_EN is defined.
package chacha_pkg;

    localparam int NUM_BITS      = 32;
    localparam int NUM_WORDS     = 16;
    localparam int BLK_CNT_W_DEF = 16;
    localparam int PTR_W         = $clog2(NUM_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_HI   = 3'd1,
        ST_UNLOAD_HI = 3'd2,
        ST_UNLOAD_LO = 3'd3,
        ST_STREAM    = 3'd4,
        ST_REQ       = 3'd5,
        ST_WAIT_LO   = 3'd6
    } state_t;

    // Count of valid bytes, LSB-first; 0 or anything above a full word means a full word.
    function automatic logic [NUM_BITS-1:0] byte_mask(input logic [2:0] nbytes);
        logic [NUM_BITS-1:0] m;
        int                  n;
        n = ((nbytes == 3'd0) || (int'(nbytes) > NUM_BITS/8)) ? NUM_BITS/8 : int'(nbytes);
        for (int b = 0; b < NUM_BITS/8; b++) begin
            m[b*8 +: 8] = (b < n) ? 8'hFF : 8'h00;
        end
        return m;
    endfunction

endpackage

// File: rtl/chacha_keystream_xor_if.sv
// Plaintext-in / ciphertext-out valid/ready stream. master = the XOR block, slave = its environment.
// Dado_Bytes exists only when CHACHA_XOR_BYTEMASK_EN is defined.
interface chacha_keystream_xor_if import chacha_pkg::*; ();

    logic [NUM_BITS-1:0] Dado_In;
    logic                Dado_Last;
    logic                Dado_Valid;
    logic                Dado_Ready;
    logic [NUM_BITS-1:0] Dado_Out;
    logic                Out_Last;
    logic                Out_Valid;
    logic                Out_Ready;
`ifdef CHACHA_XOR_BYTEMASK_EN
    logic [2:0]          Dado_Bytes;

    modport master (
        input  Dado_In, Dado_Last, Dado_Valid, Dado_Bytes, Out_Ready,
        output Dado_Ready, Dado_Out, Out_Last, Out_Valid
    );
    modport slave (
        output Dado_In, Dado_Last, Dado_Valid, Dado_Bytes, Out_Ready,
        input  Dado_Ready, Dado_Out, Out_Last, Out_Valid
    );
`else
    modport master (
        input  Dado_In, Dado_Last, Dado_Valid, Out_Ready,
        output Dado_Ready, Dado_Out, Out_Last, Out_Valid
    );
    modport slave (
        output Dado_In, Dado_Last, Dado_Valid, Out_Ready,
        input  Dado_Ready, Dado_Out, Out_Last, Out_Valid
    );
`endif

endinterface

// File: rtl/chacha_ks_buffer.sv
// One-block keystream register file: single write port, combinational read so the XOR
// can use the word in the same cycle the plaintext is accepted.
module chacha_ks_buffer import chacha_pkg::*; (
    input  logic                Clk,
    input  logic                wr_en,
    input  logic [PTR_W-1:0]    wr_ptr,
    input  logic [NUM_BITS-1:0] wr_data,
    input  logic [PTR_W-1:0]    rd_ptr,
    output logic [NUM_BITS-1:0] rd_data
);

    logic [NUM_BITS-1:0] mem_reg [NUM_WORDS];

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem_reg[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem_reg[rd_ptr];

endmodule

// File: rtl/chacha_keystream_xor.sv
// Unloads one ChaCha block into a local buffer, XORs it onto the plaintext stream and requests
// the next block when the buffer runs out or a message ends. Option: CHACHA_XOR_BYTEMASK_EN.
module chacha_keystream_xor import chacha_pkg::*; #(
    parameter int BLK_CNT_W = BLK_CNT_W_DEF
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   Habilita,
    input  logic                   Pronto,
    input  logic [NUM_BITS-1:0]    Resultado,
    output logic                   Descarrega,
    output logic                   Bloco_Req,
    chacha_keystream_xor_if.master strm,
    output logic [BLK_CNT_W-1:0]   Blocos
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_WORDS - 1);

    state_t                state_reg, state_next;
    logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
    logic [BLK_CNT_W-1:0]  blocos_reg, blocos_next;
    logic [NUM_BITS-1:0]   dout_reg, dout_next;
    logic                  out_last_reg, out_last_next;
    logic                  out_valid_reg, out_valid_next;
    logic                  descarrega_reg, bloco_req_reg;
    logic                  buf_wr_en;
    logic                  dado_ready;
    logic                  accept;
    logic [NUM_BITS-1:0]   ks_word;
    logic [NUM_BITS-1:0]   word_mask;

    chacha_ks_buffer u_buffer (
        .Clk     (Clk),
        .wr_en   (buf_wr_en),
        .wr_ptr  (wr_ptr_reg),
        .wr_data (Resultado),
        .rd_ptr  (rd_ptr_reg),
        .rd_data (ks_word)
    );

    always_comb begin
        state_next  = state_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        blocos_next = blocos_reg;
        buf_wr_en   = 1'b0;
        dado_ready  = (state_reg == ST_STREAM) && Habilita && (!out_valid_reg || strm.Out_Ready);
        accept      = dado_ready && strm.Dado_Valid;

        case (state_reg)
            ST_IDLE: begin
                if (Habilita) state_next = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (Habilita && Pronto) state_next = ST_UNLOAD_HI;
            end
            // A started strobe/capture pair always finishes; Habilita only gates the next pair.
            ST_UNLOAD_HI: begin
                if (!Pronto) begin
                    wr_ptr_next = '0;
                    state_next  = ST_WAIT_HI;
                end else begin
                    state_next  = ST_UNLOAD_LO;
                end
            end
            ST_UNLOAD_LO: begin
                if (!Pronto) begin
                    wr_ptr_next = '0;
                    state_next  = ST_WAIT_HI;
                end else begin
                    buf_wr_en   = 1'b1;
                    wr_ptr_next = wr_ptr_reg + 1'b1;
                    if (wr_ptr_reg == LAST_PTR) begin
                        blocos_next = blocos_reg + 1'b1;
                        rd_ptr_next = '0;
                        state_next  = ST_STREAM;
                    end else begin
                        state_next  = Habilita ? ST_UNLOAD_HI : ST_WAIT_HI;
                    end
                end
            end
            ST_STREAM: begin
                if (accept) begin
                    rd_ptr_next = rd_ptr_reg + 1'b1;
                    if ((rd_ptr_reg == LAST_PTR) || strm.Dado_Last) state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                wr_ptr_next = '0;
                state_next  = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                if (Habilita && !Pronto) state_next = ST_WAIT_HI;
            end
            default: state_next = ST_IDLE;
        endcase
    end

`ifdef CHACHA_XOR_BYTEMASK_EN
    assign word_mask = strm.Dado_Last ? byte_mask(strm.Dado_Bytes) : '1;
`else
    assign word_mask = '1;
`endif

    always_comb begin
        dout_next      = dout_reg;
        out_last_next  = out_last_reg;
        out_valid_next = out_valid_reg;
        if (accept) begin
            dout_next      = (strm.Dado_In ^ ks_word) & word_mask;
            out_last_next  = strm.Dado_Last;
            out_valid_next = 1'b1;
        end else if (strm.Out_Ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg      <= ST_IDLE;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            blocos_reg     <= '0;
            dout_reg       <= '0;
            out_last_reg   <= 1'b0;
            out_valid_reg  <= 1'b0;
            descarrega_reg <= 1'b0;
            bloco_req_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            blocos_reg     <= blocos_next;
            dout_reg       <= dout_next;
            out_last_reg   <= out_last_next;
            out_valid_reg  <= out_valid_next;
            descarrega_reg <= (state_next == ST_UNLOAD_HI);
            bloco_req_reg  <= (state_next == ST_REQ);
        end
    end

    assign Descarrega      = descarrega_reg;
    assign Bloco_Req       = bloco_req_reg;
    assign Blocos          = blocos_reg;
    assign strm.Dado_Ready = dado_ready;
    assign strm.Dado_Out   = dout_reg;
    assign strm.Out_Last   = out_last_reg;
    assign strm.Out_Valid  = out_valid_reg;

endmodule

// File: tb/tb_chacha_keystream_xor.sv
// Directed/random bench for chacha_keystream_xor with a word-level core model and a keystream
// reference that tracks block/word use per message. Define CHACHA_XOR_BYTEMASK_EN for the tail-mask step.
module tb_chacha_keystream_xor;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } exp_t;

    logic        Clk;
    logic        Reset_n;
    logic        Habilita;
    logic        Pronto;
    logic [31:0] Resultado;
    logic        Descarrega;
    logic        Bloco_Req;
    logic [15:0] Blocos;

    chacha_keystream_xor_if strm_if ();

    chacha_keystream_xor dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Habilita   (Habilita),
        .Pronto     (Pronto),
        .Resultado  (Resultado),
        .Descarrega (Descarrega),
        .Bloco_Req  (Bloco_Req),
        .strm       (strm_if),
        .Blocos     (Blocos)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] ks_all [$];
    exp_t        exp_q  [$];
    int          ref_blk  = 0;
    int          ref_word = 0;
    int          ref_ends = 0;

    int c_blk   = 0;
    int c_idx   = 0;
    int c_delay = 2;
    int c_done  = 0;
    int req_cnt = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Core model: presents a block once enough words are queued; each strobe delivers the next word.
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Pronto    <= 1'b0;
            Resultado <= 32'h0;
            c_idx     <= 0;
            c_delay   <= 2;
            c_done    <= 0;
        end else begin
            if (Bloco_Req) begin
                req_cnt <= req_cnt + 1;
                Pronto  <= 1'b0;
                c_blk   <= c_blk + 1;
                c_idx   <= 0;
                c_delay <= 2;
            end else if (!Pronto) begin
                if (c_delay != 0) c_delay <= c_delay - 1;
                else if (ks_all.size() >= (c_blk + 1) * 16) Pronto <= 1'b1;
            end
            if (Descarrega && Pronto && c_idx < 16) begin
                Resultado <= ks_all[c_blk*16 + c_idx];
                c_idx     <= c_idx + 1;
                if (c_idx == 15) c_done <= c_done + 1;
            end
        end
    end

    always @(negedge Clk) begin
        if (Reset_n && strm_if.Out_Valid && strm_if.Out_Ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("out  data=%h last=%0d expected=%h", strm_if.Dado_Out, strm_if.Out_Last, e.d);
                chk("dado_out", strm_if.Dado_Out, e.d);
                chk("out_last", {31'd0, strm_if.Out_Last}, {31'd0, e.l});
            end
        end
    end

    task automatic push_block(input int pat);
        for (int i = 0; i < 16; i++) begin
            case (pat)
                0:       ks_all.push_back(32'h1000_0000 + i);
                1:       ks_all.push_back(32'hA5A5_A5A5);
                3:       ks_all.push_back((i == 0) ? 32'h1122_3344 : $urandom);
                default: ks_all.push_back($urandom);
            endcase
        end
    endtask

    task automatic send_word(input logic [31:0] pt, input logic last, input logic [2:0] nb);
        int          idx;
        int          n;
        logic [31:0] ks;
        logic [31:0] m;
        exp_t        e;
        idx = ref_blk * 16 + ref_word;
        ks  = (idx < ks_all.size()) ? ks_all[idx] : 32'h0;
        m   = 32'hFFFF_FFFF;
`ifdef CHACHA_XOR_BYTEMASK_EN
        if (last) begin
            int          nn;
            logic [63:0] wide;
            nn   = (nb == 3'd0 || nb > 3'd4) ? 4 : int'(nb);
            wide = (64'd1 << (8 * nn)) - 64'd1;
            m    = wide[31:0];
        end
        strm_if.Dado_Bytes = nb;
`endif
        e.d = (pt ^ ks) & m;
        e.l = last;
        exp_q.push_back(e);
        ref_word++;
        if (last || ref_word == 16) begin
            ref_blk++;
            ref_word = 0;
            ref_ends++;
        end
        $display("in   data=%h last=%0d nbytes=%0d", pt, last, nb);
        strm_if.Dado_In    = pt;
        strm_if.Dado_Last  = last;
        strm_if.Dado_Valid = 1'b1;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!strm_if.Dado_Ready && n < 400);
        chk("dado_ready_wait", {31'd0, strm_if.Dado_Ready}, 32'd1);
        @(posedge Clk);
        #1;
        strm_if.Dado_Valid = 1'b0;
        strm_if.Dado_Last  = 1'b0;
    endtask

    task automatic send_msg(input int n, input int pat, input int stall, input logic [2:0] nb);
        logic [31:0] pt;
        for (int i = 0; i < n; i++) begin
            pt = (pat == 0) ? 32'h0 : (pat == 1) ? 32'hFFFF_FFFF : $urandom;
            if (i == stall) begin
                strm_if.Out_Ready  = 1'b0;
                strm_if.Dado_In    = pt;
                strm_if.Dado_Valid = 1'b1;
                repeat (5) begin
                    @(negedge Clk);
                    chk("stall_ready", {31'd0, strm_if.Dado_Ready}, 32'd0);
                    chk("stall_valid", {31'd0, strm_if.Out_Valid}, 32'd1);
                    chk("stall_hold", strm_if.Dado_Out, (exp_q.size() > 0) ? exp_q[0].d : 32'hDEAD_BEEF);
                end
                @(posedge Clk);
                #1;
                strm_if.Out_Ready = 1'b1;
            end
            send_word(pt, (i == n - 1), nb);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge Clk);
            n++;
        end
        repeat (6) @(posedge Clk);
        #1;
        chk("drain", exp_q.size(), 32'd0);
        chk("req_pulses", req_cnt, ref_ends);
        chk("blocos_vs_core", {16'd0, Blocos}, c_done);
    endtask

    initial begin
        int n;
        Reset_n            = 1'b0;
        Habilita           = 1'b0;
        strm_if.Dado_In    = 32'h0;
        strm_if.Dado_Last  = 1'b0;
        strm_if.Dado_Valid = 1'b0;
        strm_if.Out_Ready  = 1'b1;
`ifdef CHACHA_XOR_BYTEMASK_EN
        strm_if.Dado_Bytes = 3'd0;
`endif
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_descarrega", {31'd0, Descarrega}, 32'd0);
        chk("rst_bloco_req",  {31'd0, Bloco_Req}, 32'd0);
        chk("rst_dado_ready", {31'd0, strm_if.Dado_Ready}, 32'd0);
        chk("rst_out_valid",  {31'd0, strm_if.Out_Valid}, 32'd0);
        chk("rst_dado_out",   strm_if.Dado_Out, 32'd0);
        chk("rst_blocos",     {16'd0, Blocos}, 32'd0);
        Reset_n  = 1'b1;
        Habilita = 1'b1;

        // 1: counting keystream, zero plaintext, one full-block message
        push_block(0);
        send_msg(16, 0, -1, 3'd0);
        wait_drain();
        chk("t1_blocos", {16'd0, Blocos}, 32'd1);
        chk("t1_req", req_cnt, 32'd1);

        // 2: two 8-word messages of all-ones over two constant blocks
        push_block(1);
        push_block(1);
        send_msg(8, 1, -1, 3'd0);
        send_msg(8, 1, -1, 3'd0);
        wait_drain();
        chk("t2_last_out", strm_if.Dado_Out, 32'h5A5A_5A5A);
        chk("t2_blocos", {16'd0, Blocos}, 32'd3);

        // 3: short message ends the block early; the next message starts on a fresh block
        push_block(2);
        push_block(2);
        send_msg(3, 2, -1, 3'd0);
        wait_drain();
        send_msg(5, 2, -1, 3'd0);
        wait_drain();

        // 4: sink back-pressure mid-stream
        push_block(2);
        send_msg(16, 2, 6, 3'd0);
        wait_drain();

        // 5: reset while capturing word 7; unload must restart at word 0
        push_block(2);
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!(c_idx == 8 && !Descarrega && Pronto) && n < 300);
        chk("t5_reach_word7", {31'd0, (n < 300)}, 32'd1);
        Reset_n = 1'b0;
        #1;
        chk("t5_descarrega", {31'd0, Descarrega}, 32'd0);
        chk("t5_out_valid",  {31'd0, strm_if.Out_Valid}, 32'd0);
        chk("t5_out_last",   {31'd0, strm_if.Out_Last}, 32'd0);
        chk("t5_dado_out",   strm_if.Dado_Out, 32'd0);
        chk("t5_blocos",     {16'd0, Blocos}, 32'd0);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        send_msg(16, 2, -1, 3'd0);
        wait_drain();
        chk("t5_blocos_after", {16'd0, Blocos}, 32'd1);

`ifdef CHACHA_XOR_BYTEMASK_EN
        // 6: two-byte tail word
        push_block(3);
        send_msg(1, 0, -1, 3'd2);
        wait_drain();
        chk("t6_bytemask", strm_if.Dado_Out, 32'h0000_3344);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
